// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the DW-bit Fibonacci LFSR pattern
// generator. It seeds itself from received words, confirms the seed over
// LOCK_CNT correct predictions, then flywheels its own sequence. While
// flywheeling it reports per-word mismatches and keeps a saturating count.
module lfsr_checker #(
    parameter int DW       = 6,
    parameter int TAP_A    = 4,
    parameter int TAP_B    = 1,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CW       = 16
) (
    input  logic          i_clk_chk,
    input  logic          i_rst_n_chk,
    input  logic          i_en_chk,
    input  logic [DW-1:0] i_data_chk,
    input  logic          i_clr_chk,
    output logic          o_locked_chk,
    output logic          o_err_chk,
    output logic [CW-1:0] o_err_cnt_chk
);

    // Counter widths sized so the terminal values LOCK_CNT-1 / LOSS_CNT-1 fit.
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    // One generator step: shift left, feedback bit enters at the LSB.
    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
        return {x[DW-2:0], x[TAP_A] ^ x[TAP_B]};
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   ref_q, ref_d;
    logic [MW-1:0]   match_q, match_d;
    logic [LW-1:0]   miss_q, miss_d;
    logic            err_d;
    logic            locked_d;
    logic [CW-1:0]   cnt_d;

    logic [DW-1:0]   pred;
    logic            hit;
    logic            nonzero;

    assign pred    = lfsr_next(ref_q);
    assign hit     = (i_data_chk == pred);
    assign nonzero = |i_data_chk;

    // State, prediction, run counters and all outputs are registered here.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk_chk or negedge i_rst_n_chk) begin
        if (!i_rst_n_chk) begin
            state_q       <= SEARCH;
            ref_q         <= '0;
            match_q       <= '0;
            miss_q        <= '0;
            o_locked_chk  <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_cnt_chk <= '0;
        end else begin
            state_q       <= state_d;
            ref_q         <= ref_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            o_locked_chk  <= locked_d;
            o_err_chk     <= err_d;
            o_err_cnt_chk <= cnt_d;
        end
    end

    // Next-state: seed in SEARCH, confirm in VERIFY, flywheel in LOCKED.
    // NOTE: every signal gets a hold value before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (i_en_chk) begin
            unique case (state_q)
                SEARCH: begin
                    // All-zero is the LFSR lock-up word and cannot seed.
                    if (nonzero) begin
                        ref_d   = i_data_chk;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        ref_d = i_data_chk;
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else if (nonzero) begin
                        ref_d   = i_data_chk;
                        match_d = '0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    // Prediction advances on its own so a bad word cannot
                    // knock the flywheel out of alignment.
                    ref_d = pred;
                    if (hit) begin
                        miss_d = '0;
                    end else if (miss_q == LW'(LOSS_CNT - 1)) begin
                        state_d = SEARCH;
                    end else begin
                        miss_d = miss_q + LW'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Output decode: error pulse, saturating count (clear wins), lock flag.
    always_comb begin
        err_d    = i_en_chk && (state_q == LOCKED) && !hit;
        locked_d = (state_d == LOCKED);
        cnt_d    = o_err_cnt_chk;
        if (i_clr_chk) begin
            cnt_d = '0;
        end else if (err_d && (o_err_cnt_chk != CNT_MAX)) begin
            cnt_d = o_err_cnt_chk + CW'(1);
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: two checkers (default, and CW=2/LOSS_CNT=8) share one
// stimulus stream. A behavioural model predicts each cycle's outputs into
// per-instance queues; an independent monitor pops and compares after edges.
module tb_lfsr_checker;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [5:0]  data;
    logic        clr;
    logic        locked0, err0, locked1, err1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    obs_t q0[$];
    obs_t q1[$];
    int   checks;
    int   errors;

    // Model state, one slot per instance (0 = defaults, 1 = CW=2/LOSS_CNT=8).
    int m_mode[2];   // 0 searching, 1 verifying, 2 locked
    int m_ref[2];
    int m_run[2];
    int m_miss[2];
    int m_cnt[2];
    int loss_lim[2] = '{3, 8};
    int cnt_max[2]  = '{65535, 3};

    lfsr_checker u_dut0 (
        .i_clk_chk    (clk),
        .i_rst_n_chk  (rst_n),
        .i_en_chk     (en),
        .i_data_chk   (data),
        .i_clr_chk    (clr),
        .o_locked_chk (locked0),
        .o_err_chk    (err0),
        .o_err_cnt_chk(cnt0)
    );

    lfsr_checker #(.CW(2), .LOSS_CNT(8)) u_dut1 (
        .i_clk_chk    (clk),
        .i_rst_n_chk  (rst_n),
        .i_en_chk     (en),
        .i_data_chk   (data),
        .i_clr_chk    (clr),
        .o_locked_chk (locked1),
        .o_err_chk    (err1),
        .o_err_cnt_chk(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Next generator word by plain arithmetic on a 6-bit integer (taps 4 and 1).
    function automatic int nxt(input int x);
        return ((x << 1) & 63) | (((x >> 4) ^ (x >> 1)) & 1);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got locked=%0b err=%0b cnt=%0d, want locked=%0b err=%0b cnt=%0d",
                     name, $time, act.locked, act.err, act.cnt, exp.locked, exp.err, exp.cnt);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = 0;
            m_ref[m]  = 0;
            m_run[m]  = 0;
            m_miss[m] = 0;
            m_cnt[m]  = 0;
        end
    endtask

    task automatic model_step(input bit e, input int d, input bit c);
        for (int m = 0; m < 2; m++) begin
            obs_t o;
            int   p;
            bit   err;
            err = 1'b0;
            if (e) begin
                p = nxt(m_ref[m]);
                if (m_mode[m] == 0) begin
                    if (d != 0) begin
                        m_ref[m] = d; m_run[m] = 0; m_mode[m] = 1;
                    end
                end else if (m_mode[m] == 1) begin
                    if (d == p) begin
                        m_ref[m] = d;
                        m_run[m]++;
                        if (m_run[m] == 4) begin
                            m_mode[m] = 2; m_miss[m] = 0;
                        end
                    end else if (d != 0) begin
                        m_ref[m] = d; m_run[m] = 0;
                    end else begin
                        m_mode[m] = 0;
                    end
                end else begin
                    m_ref[m] = p;
                    if (d == p) begin
                        m_miss[m] = 0;
                    end else begin
                        err = 1'b1;
                        if (m_cnt[m] < cnt_max[m]) m_cnt[m]++;
                        m_miss[m]++;
                        if (m_miss[m] == loss_lim[m]) m_mode[m] = 0;
                    end
                end
            end
            if (c) m_cnt[m] = 0;
            o.locked = (m_mode[m] == 2);
            o.err    = err;
            o.cnt    = 16'(m_cnt[m]);
            if (m == 0) q0.push_back(o);
            else        q1.push_back(o);
        end
    endtask

    // One stimulus cycle: drive just after the falling edge, record expectation.
    task automatic beat(input bit e, input int d, input bit c);
        @(negedge clk);
        #1;
        en   = e;
        data = 6'(d);
        clr  = c;
        model_step(e, d, c);
    endtask

    task automatic check_zero_outputs(input string tag);
        obs_t a;
        obs_t z;
        z = '0;
        a.locked = locked0; a.err = err0; a.cnt = cnt0;
        check({tag, "_dut0"}, a, z);
        a.locked = locked1; a.err = err1; a.cnt = 16'(cnt1);
        check({tag, "_dut1"}, a, z);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic async_reset();
        beat(0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the scoreboard holds after each rising edge.
    initial begin
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                a.locked = locked0; a.err = err0; a.cnt = cnt0;
                check("dut0", a, q0.pop_front());
            end
            if (q1.size() > 0) begin
                a.locked = locked1; a.err = err1; a.cnt = 16'(cnt1);
                check("dut1", a, q1.pop_front());
            end
        end
    end

    initial begin
        int lock_seq[5] = '{1, 2, 5, 10, 21};
        int g;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        data   = '0;
        clr    = 1'b0;
        model_reset();
        #3;
        check_zero_outputs("reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Lock on five consecutive words.
        foreach (lock_seq[i]) beat(1, lock_seq[i], 0);
        // Single bad word while locked, then the correctly aligned next word.
        beat(1, 0, 0);
        beat(1, 23, 0);
        beat(0, 0, 1);
        // Three wrong words drop lock; a fresh word restarts verification.
        repeat (3) beat(1, 63, 0);
        beat(1, 1, 0);

        async_reset();

        // Zeros ignored while searching; lock sequence with idle gaps.
        beat(1, 0, 0);
        beat(1, 0, 0);
        foreach (lock_seq[i]) begin
            beat(1, lock_seq[i], 0);
            beat(0, 0, 0);
        end
        // Five errors: narrow counter saturates; clear on the fifth wins.
        repeat (4) beat(1, 63, 0);
        beat(1, 63, 1);
        beat(0, 0, 0);

        // Randomized: generator stream with corruption, gaps and clears.
        g = $urandom_range(1, 63);
        for (int i = 0; i < 600; i++) begin
            bit e;
            bit c;
            int d;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 29) == 0);
            d = 0;
            if (e) begin
                d = g;
                if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 63);
                else if ($urandom_range(0, 99) == 0) d = 0;
                g = nxt(g);
            end
            beat(e, d, c);
        end
        beat(0, 0, 0);

        for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        #2;
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d entries pending, want 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side partner to the team's DW-bit Fibonacci LFSR pattern generator.
- Generator recurrence per enabled beat: next = {cur[DW-2:0], cur[TAP_A] ^ cur[TAP_B]}.
- Consumes the word stream on valid beats, self-synchronises by seeding from received data, then flywheels its own prediction.
- Reports lock status, per-word error pulses and a saturating error count. Used for RAM/datapath built-in self-test and link checks.

Parameters:
- DW, 6, word width; must be >= 2.
- TAP_A, 4, first feedback tap; must be < DW-1.
- TAP_B, 1, second feedback tap; must be < DW-1 and != TAP_A.
- LOCK_CNT, 4, consecutive correct predictions in VERIFY needed to enter LOCKED; >= 1.
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop back to SEARCH; >= 1.
- CW, 16, error counter width.

Ports:
- i_clk_chk  in  1  clock; all state updates on rising edge.
- i_rst_n_chk  in  1  reset, asynchronous assert, active-low.
- i_en_chk  in  1  word valid; i_data_chk is sampled only when high.
- i_data_chk  in  DW  received LFSR word.
- i_clr_chk  in  1  synchronous clear of o_err_cnt_chk.
- o_locked_chk  out  1  high while in LOCKED.
- o_err_chk  out  1  one-cycle pulse per mismatched word in LOCKED.
- o_err_cnt_chk  out  CW  saturating mismatch count.

Interface decision: one clock; reset is asynchronous and active-low. Clock port is i_clk_chk; reset port is i_rst_n_chk.

Behaviour:
- f(x) = {x[DW-2:0], x[TAP_A]^x[TAP_B]}. ref is an internal DW-bit register.
- Reset (async, while i_rst_n_chk=0): state=SEARCH, ref=0, match_cnt=0, miss_cnt=0, o_locked_chk=0, o_err_chk=0, o_err_cnt_chk=0.
- All outputs are registered. Response to a word sampled at edge N is visible after edge N.
- i_en_chk=0: no state or counter change; o_err_chk=0. Gaps of any length between valid beats are legal.
- SEARCH:
  - Valid nonzero word: ref<=word, match_cnt<=0, go VERIFY.
  - All-zero word: ignored (LFSR lock-up value, not seedable).
- VERIFY:
  - Valid word w == f(ref): ref<=w, match_cnt++. If match_cnt+1 == LOCK_CNT, go LOCKED with miss_cnt<=0.
  - Valid word w != f(ref), w nonzero: reseed with ref<=w, match_cnt<=0, stay in VERIFY.
  - Valid word w != f(ref), w zero: go SEARCH.
  - No error pulses or counting occur in VERIFY.
- LOCKED (flywheel):
  - On each valid beat, ref<=f(ref) regardless of the data.
  - Match: miss_cnt<=0.
  - Mismatch: o_err_chk=1 for one cycle, o_err_cnt_chk increments (saturating at 2^CW-1), miss_cnt++. If miss_cnt+1 == LOSS_CNT, go SEARCH and o_locked_chk falls on the same edge.
- o_locked_chk = (state==LOCKED), registered.
- i_clr_chk=1: o_err_cnt_chk<=0. If it coincides with a mismatch, clear wins (count=0) but o_err_chk still pulses. i_clr_chk does not affect state.
- Reset mid-operation: outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
- Default parameters, words 000001, 000010, 000101, 001010, 010101 on consecutive valid beats -> o_locked_chk rises after the 5th word, o_err_cnt_chk=0, o_err_chk never high.
- Locked after the previous scenario, send 000000 where 101011 is due, then 010111 -> exactly one o_err_chk pulse, o_err_cnt_chk=1, o_locked_chk stays 1 (flywheel keeps prediction aligned).
- Locked, send 3 consecutive wrong words (111111 x3) -> three pulses, o_err_cnt_chk=3, o_locked_chk=0 after the third, subsequent 000001 restarts VERIFY.
- SEARCH with 000000, 000000, then the lock sequence with i_en_chk toggled low between words -> zeros ignored, lock achieved identically to the first scenario.
- CW=2, LOSS_CNT=8: 5 errors while locked -> o_err_cnt_chk saturates at 3; i_clr_chk asserted on the 5th error -> count 0, pulse still seen.
- Locked, drop i_rst_n_chk between clock edges -> o_locked_chk and o_err_cnt_chk go to 0 before the next edge; after release the checker is in SEARCH.
